md_issue_buf: RTL
=================

# md_issue_buf

Issue buffer between the E-stage decode of multiply/divide-class instructions and the `xlu` HI/LO unit. It queues mult/multu/div/divu/mthi/mtlo requests in program order and issues each to `xlu` as a single-cycle op pulse only when `xlu` can take it. It raises `stall_d` so the pipeline stalls only when the queue is full or an mfhi/mflo would read stale HI/LO.

## Interface
Parameters:
- `DEPTH`, 2: queue entries; must be a power of two and at least 2.

Ports:
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: E stage presents an md-class instruction.
- `in_op` in 4: operation code.
  - 0000 mult, 0001 multu, 0010 div, 0011 divu, 0100 mthi, 0101 mtlo: write class.
  - 0110 mfhi, 0111 mflo: read class.
  - 1000: none.
- `in_a` in 32: rs operand.
- `in_b` in 32: rt operand.
- `hold_issue` in 1: intreq | eretop; blocks issue this cycle.
- `xlu_busy` in 1: `busy` from `xlu`.
- `stall_d` out 1: combinational; freeze D/E this cycle.
- `xlu_op` out 4, registered: op driven to `xlu`.
- `xlu_in1` out 32, registered: operand to `xlu`.
- `xlu_in2` out 32, registered: operand to `xlu`.
- `q_count` out $clog2(DEPTH)+1: current queue occupancy.

## Operation
- Reset values: `xlu_op`=4'b1000, `xlu_in1`=`xlu_in2`=0, `q_count`=0, queue empty, `stall_d`=0.
- Enqueue condition: `in_valid` & write-class `in_op` & !`stall_d`. The entry {op, a, b} is written at the tail on that edge.
- `stall_d` is asserted when either of these holds:
  - `in_valid` & write-class & queue full. Full is judged before any same-cycle dequeue, so there is no enqueue on a full queue.
  - `in_valid` & read-class & (queue non-empty | `xlu_op`≠1000 | `xlu_busy`).
- Read-class ops and op 1000 are never enqueued. Read-class ops proceed to `xlu` HI/LO outputs directly once the stall clears.
- Issue condition, evaluated each cycle: queue non-empty & !`xlu_busy` & !`hold_issue` & !`just_started`.
  - `just_started` is a flag register set on any edge that loads a start-class op (0000–0011) into `xlu_op`. It covers the cycle before `xlu_busy` rises.
- On issue: the head is popped and loaded into `xlu_op`/`xlu_in1`/`xlu_in2`.
- When no issue occurs, `xlu_op` is reloaded with 1000. Operands hold their last value.
- `xlu_op` is therefore non-1000 for exactly one cycle per entry.
- mthi/mtlo (0100/0101) do not set `just_started`. They may be issued back-to-back.
- Queued entries are architecturally committed and are never flushed by `hold_issue`. Issue only pauses while `hold_issue` is high.
- Reset mid-operation: queue emptied, `just_started` cleared, `xlu_op`=1000 on the same edge.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Occupancy is tracked separately from the pointers, so full and empty are unambiguous.

## Timing
- Enqueue at edge E0. With `xlu` idle, `xlu_op` carries the op during cycle E1→E2, and `xlu` latches at E2 (`busy`=1 from E2).
- Minimum enqueue-to-`xlu` latency: 1 cycle.
- Back-to-back start-class issues are at least 2 cycles apart. After that, issue is gated by `xlu_busy`.
- An mfhi/mflo stalls until the cycle after the last `xlu_busy` high cycle, with the queue empty and `xlu_op`=1000.
- Simultaneous enqueue and issue on a non-full queue: both occur; `q_count` is unchanged.

## Configuration
- `MDQ_STATS_EN` defined:
  - Adds output `stall_cycles` (32 bits, reset 0). It increments by 1 on every edge where `stall_d`=1 and saturates at 32'hFFFFFFFF.
  - Adds output `issue_count` (32 bits, reset 0). It increments on every issue and wraps.
- `MDQ_STATS_EN` undefined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- Shared package `md_pkg` holds:
  - Op-code constants `MD_MULT`…`MD_MFLO`, `MD_NONE`=4'b1000.
  - Classifier functions `md_is_start`, `md_is_write`, `md_is_read`.
- `xlu` and this block both use `md_pkg`.
- One sub-module, `mdq_fifo`: parameterised DEPTH×68-bit synchronous FIFO providing push, pop, head, full, empty, and count.
- Stall and issue logic stay in `md_issue_buf`.

## Test plan
- mult with a=3, b=5 while idle → `xlu_op`=0000 for exactly one cycle, 1 cycle after enqueue. Next cycle `xlu_op`=1000 and `q_count`=0.
- div, mult, mthi enqueued on consecutive cycles with `xlu_busy` asserted high for 10 cycles after each start → issues occur in order. Each issue follows `xlu_busy` falling; `stall_d` stays 0 throughout (DEPTH=2 holds the two trailing entries).
- Third write-class op with the queue full (DEPTH=2) → `stall_d`=1. The op is enqueued on the first edge after a pop makes room.
- mflo presented while `xlu_busy`=1 → `stall_d`=1 until the queue is empty, `xlu_op`=1000 and busy=0, then 0.
- `hold_issue`=1 for 3 cycles with a queued multu → no issue during those cycles; `xlu_op`=0001 on the edge after `hold_issue` falls; the entry is not lost.
- `reset` asserted with 2 entries queued and `xlu_op`=0010 → next cycle `q_count`=0, `xlu_op`=1000, `stall_d`=0. With `MDQ_STATS_EN`, both counters read 0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared mul/div op-code constants, queue-entry layout and op classifiers,
// used by md_issue_buf and the xlu HI/LO unit.
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'b0000;
  localparam logic [3:0] MD_MULTU = 4'b0001;
  localparam logic [3:0] MD_DIV   = 4'b0010;
  localparam logic [3:0] MD_DIVU  = 4'b0011;
  localparam logic [3:0] MD_MTHI  = 4'b0100;
  localparam logic [3:0] MD_MTLO  = 4'b0101;
  localparam logic [3:0] MD_MFHI  = 4'b0110;
  localparam logic [3:0] MD_MFLO  = 4'b0111;
  localparam logic [3:0] MD_NONE  = 4'b1000;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } md_entry_t;

  localparam int MD_ENTRY_W = $bits(md_entry_t);

  // Ops that keep xlu busy for several cycles (mult/multu/div/divu).
  function automatic logic md_is_start(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

  // Ops that update HI/LO and therefore go through the queue.
  function automatic logic md_is_write(input logic [3:0] op);
    return !op[3] && (op[2:1] != 2'b11);
  endfunction

  function automatic logic md_is_read(input logic [3:0] op);
    return op[3:1] == 3'b011;
  endfunction

endpackage

// File: rtl/mdq_fifo.sv
// DEPTH-entry synchronous FIFO for md queue entries; occupancy is counted
// separately from the wrapping pointers so full and empty never alias.
module mdq_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 68
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && (r_count != PW'(0) + (PW+1)'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // NOTE: storage carries no reset; a slot is only ever read after it was
  // written, so only the pointers and the count need clearing.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: all state is updated with <= so every register samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/md_issue_buf.sv
// Program-order issue buffer between E-stage mul/div decode and xlu.
// Optional statistics counters are enabled by defining MDQ_STATS_EN.
module md_issue_buf
  import md_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [3:0]               in_op,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic                     hold_issue,
  input  logic                     xlu_busy,
  output logic                     stall_d,
  output logic [3:0]               xlu_op,
  output logic [31:0]              xlu_in1,
  output logic [31:0]              xlu_in2,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef MDQ_STATS_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              issue_count
`endif
);

  logic      w_in_write;
  logic      w_in_read;
  logic      w_full;
  logic      w_empty;
  logic      w_push;
  logic      w_issue;
  md_entry_t w_in_entry;
  md_entry_t w_head;
  logic      r_just_started;

  assign w_in_write = in_valid && md_is_write(in_op);
  assign w_in_read  = in_valid && md_is_read(in_op);
  assign w_in_entry = '{op: in_op, a: in_a, b: in_b};

  // Full is judged before any same-cycle pop, so a full queue never accepts.
  assign stall_d = (w_in_write && w_full) ||
                   (w_in_read && (!w_empty || (xlu_op != MD_NONE) || xlu_busy));

  assign w_push  = w_in_write && !stall_d;
  assign w_issue = !w_empty && !xlu_busy && !hold_issue && !r_just_started;

  mdq_fifo #(
    .DEPTH (DEPTH),
    .W     (MD_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_issue),
    .i_data  (w_in_entry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (q_count)
  );

  // just_started masks the one cycle between a start op leaving and xlu_busy rising.
  always_ff @(posedge clk) begin
    if (reset) begin
      xlu_op         <= MD_NONE;
      xlu_in1        <= '0;
      xlu_in2        <= '0;
      r_just_started <= 1'b0;
    end else if (w_issue) begin
      xlu_op         <= w_head.op;
      xlu_in1        <= w_head.a;
      xlu_in2        <= w_head.b;
      r_just_started <= md_is_start(w_head.op);
    end else begin
      xlu_op         <= MD_NONE;
      r_just_started <= 1'b0;
    end
  end

`ifdef MDQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      if (stall_d && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 1'b1;
      if (w_issue) issue_count <= issue_count + 1'b1;
    end
  end
`endif

endmodule
